// File: rtl/mod_i2s_tx.sv
// mod_i2s_tx: I2S master transmitter.
// Divides clk into bclk, generates lrclk and shifts stereo pairs out MSB first
// with the standard one-slot delay after each lrclk edge. Sample pairs arrive
// through a valid/ready handshake into a one-deep holding register.
// Optional build macro: I2S_TX_REPEAT_ON_UNDERRUN_EN -- when defined, an
// underrun load resends the last loaded pair instead of zeros.
module mod_i2s_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] sample_left,
    input  logic [DATA_WIDTH-1:0] sample_right,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  data_line,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int SLOTS = 2 * DATA_WIDTH;
    localparam int SW    = $clog2(SLOTS);
    localparam int DCW   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DCW-1:0]        div_cnt;
    logic [SW-1:0]         slot;
    logic [SW-1:0]         slot_nxt;
    logic [SLOTS-1:0]      shifter;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  hold_full;
    logic [SLOTS-1:0]      load_pair;
    logic [SLOTS-1:0]      fill_pair;
    logic                  wrap;
    logic                  fall;
    logic                  load;
    logic                  accept;

    assign sample_ready = !hold_full;
    assign accept       = sample_valid && !hold_full;
    assign wrap         = enable && (div_cnt == DCW'(BCLK_DIV - 1));
    assign fall         = wrap && bclk;
    assign slot_nxt     = (slot == SW'(SLOTS - 1)) ? '0 : slot + 1'b1;
    // Loading while entering slot 1 gives the one-bclk delay after lrclk falls.
    assign load         = fall && (slot == '0);
    assign load_pair    = hold_full ? {hold_l, hold_r} : fill_pair;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [SLOTS-1:0] last_pair;

    // Remember the most recent frame so an underrun can resend it.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_pair <= '0;
        end else if (load) begin
            last_pair <= load_pair;
        end
    end

    assign fill_pair = last_pair;
`else
    assign fill_pair = '0;
`endif

    // Holding register: accept only while empty; a load empties it. Accept and
    // load-clear never coincide since accept needs the register empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= sample_left;
            hold_r    <= sample_right;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Bit clock divider; disabling parks everything at the start of a frame.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) begin
                bclk <= !bclk;
            end
        end
    end

    // Slot counter, word select and serial shifter, all advanced on bclk falls.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            slot        <= '0;
            lrclk       <= 1'b0;
            data_line   <= 1'b0;
            shifter     <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (fall) begin
                slot  <= slot_nxt;
                lrclk <= (slot_nxt >= SW'(DATA_WIDTH));
                if (load) begin
                    data_line   <= load_pair[SLOTS-1];
                    shifter     <= {load_pair[SLOTS-2:0], 1'b0};
                    frame_start <= 1'b1;
                    underrun    <= !hold_full;
                end else begin
                    data_line <= shifter[SLOTS-1];
                    shifter   <= {shifter[SLOTS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_i2s_tx.sv
// Directed bench for mod_i2s_tx (DATA_WIDTH=16, BCLK_DIV=2). A decoder samples
// data_line/lrclk on bclk rising edges the way the mod_i2s receiver does.
module tb_mod_i2s_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        data_line;
    logic        frame_start;
    logic        underrun;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    mod_i2s_tx #(.DATA_WIDTH(16), .BCLK_DIV(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .data_line    (data_line),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = !clk;

    // Cycle counter used for timing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Decoder and pulse monitor, sampled mid-cycle.
    logic [15:0] dec_l[$];
    logic [15:0] dec_r[$];
    int          fs_t[$];
    logic [15:0] sr = '0;
    logic [15:0] lw = '0;
    logic        ws_q = 1'b0;
    logic        bclk_q = 1'b0;
    int          hi = 0, tot = 0, last_hi = 0, last_tot = 0;
    int          rise_cyc = 0, bclk_per = 0;
    int          fs_cnt = 0, ur_cnt = 0, ur_alone = 0;

    always @(negedge clk) begin
        if (reset || !enable) begin
            sr   = '0;
            ws_q = 1'b0;
            hi   = 0;
            tot  = 0;
        end else if (bclk && !bclk_q) begin
            sr = {sr[14:0], data_line};
            tot++;
            if (lrclk) hi++;
            if (!ws_q && lrclk) lw = sr;
            if (ws_q && !lrclk) begin
                dec_l.push_back(lw);
                dec_r.push_back(sr);
                last_hi  = hi;
                last_tot = tot;
                hi  = 0;
                tot = 0;
            end
            ws_q     = lrclk;
            bclk_per = cyc - rise_cyc;
            rise_cyc = cyc;
        end
        bclk_q = bclk;
        if (frame_start) begin
            fs_cnt++;
            fs_t.push_back(cyc);
        end
        if (underrun) ur_cnt++;
        if (underrun && !frame_start) ur_alone++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offers a pair and returns on the negedge after the transfer edge.
    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        sample_left  = l;
        sample_right = r;
        sample_valid = 1'b1;
        while (!sample_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", {31'd0, sample_ready}, 32'd1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_dec(input int n);
        int k = 0;
        while (dec_l.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("dec_count", {31'd0, dec_l.size() >= n}, 32'd1);
    endtask

    task automatic wait_fs();
        int k = 0;
        @(negedge clk);
        while (!frame_start && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("fs_seen", {31'd0, frame_start}, 32'd1);
    endtask

    logic [15:0] exp_ul, exp_ur;
    int          base, ub;

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_left  = '0;
        sample_right = '0;
        repeat (3) @(negedge clk);
        check("rst_bclk",  {31'd0, bclk},         32'd0);
        check("rst_lrclk", {31'd0, lrclk},        32'd0);
        check("rst_data",  {31'd0, data_line},    32'd0);
        check("rst_fs",    {31'd0, frame_start},  32'd0);
        check("rst_ur",    {31'd0, underrun},     32'd0);
        check("rst_ready", {31'd0, sample_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Streaming with valid held across four pairs.
        push(16'hA5A5, 16'h3C3C);
        check("held_ready", {31'd0, sample_ready}, 32'd0);
        enable = 1'b1;
        push(16'h0001, 16'h8000);
        push(16'hFFFF, 16'h0000);
        push(16'h1234, 16'h5678);
        wait_dec(4);
        check("p0_l", {16'd0, dec_l[0]}, 32'h0000A5A5);
        check("p0_r", {16'd0, dec_r[0]}, 32'h00003C3C);
        check("p1_l", {16'd0, dec_l[1]}, 32'h00000001);
        check("p1_r", {16'd0, dec_r[1]}, 32'h00008000);
        check("p2_l", {16'd0, dec_l[2]}, 32'h0000FFFF);
        check("p2_r", {16'd0, dec_r[2]}, 32'h00000000);
        check("p3_l", {16'd0, dec_l[3]}, 32'h00001234);
        check("p3_r", {16'd0, dec_r[3]}, 32'h00005678);
        check("fs_gap1", fs_t[1] - fs_t[0], 32'd128);
        check("fs_gap2", fs_t[2] - fs_t[1], 32'd128);
        check("fs_gap3", fs_t[3] - fs_t[2], 32'd128);
        check("fs_cnt4", fs_cnt, 32'd4);
        check("ur_none", ur_cnt, 32'd0);
        check("bclk_per", bclk_per, 32'd4);
        check("lr_hi",    last_hi,  32'd16);
        check("lr_tot",   last_tot, 32'd32);

        // Starved: every load underruns.
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        exp_ul = 16'h1234;
        exp_ur = 16'h5678;
`else
        exp_ul = 16'h0000;
        exp_ur = 16'h0000;
`endif
        wait_dec(6);
        check("u4_l", {16'd0, dec_l[4]}, {16'd0, exp_ul});
        check("u4_r", {16'd0, dec_r[4]}, {16'd0, exp_ur});
        check("u5_l", {16'd0, dec_l[5]}, {16'd0, exp_ul});
        check("u5_r", {16'd0, dec_r[5]}, {16'd0, exp_ur});
        check("ur_cnt2",  ur_cnt,   32'd2);
        check("fs_cnt6",  fs_cnt,   32'd6);
        check("ur_alone", ur_alone, 32'd0);

        // Reset in slot 7 with a pair pending.
        wait_fs();
        push(16'hDEAD, 16'hBEEF);
        repeat (23) @(negedge clk);
        check("pre_rst_bclk_run", {31'd0, sample_ready}, 32'd0);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("mrst_bclk",  {31'd0, bclk},         32'd0);
        check("mrst_lrclk", {31'd0, lrclk},        32'd0);
        check("mrst_data",  {31'd0, data_line},    32'd0);
        check("mrst_fs",    {31'd0, frame_start},  32'd0);
        check("mrst_ur",    {31'd0, underrun},     32'd0);
        check("mrst_ready", {31'd0, sample_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, sample_ready}, 32'd1);

        // Disable in slot 20 with a pair held, then re-enable.
        enable = 1'b1;
        wait_fs();
        push(16'h5A5A, 16'hC3C3);
        repeat (75) @(negedge clk);
        check("s20_lrclk", {31'd0, lrclk}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_bclk",  {31'd0, bclk},         32'd0);
        check("dis_lrclk", {31'd0, lrclk},        32'd0);
        check("dis_data",  {31'd0, data_line},    32'd0);
        check("dis_ready", {31'd0, sample_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check("dis_ready_hold", {31'd0, sample_ready}, 32'd0);
        base   = dec_l.size();
        ub     = ur_cnt;
        enable = 1'b1;
        wait_dec(base + 1);
        check("re_l", {16'd0, dec_l[base]}, 32'h00005A5A);
        check("re_r", {16'd0, dec_r[base]}, 32'h0000C3C3);
        check("re_ur", ur_cnt - ub, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
